regs_bus_arbiter: RTL and testbench
===================================

Name: regs_bus_arbiter

Overview:
Shares the single CPU-side register-file port (addr/we/re/write_data/read_data) between the two cores of the dual-core system. It uses round-robin arbitration with an optional bounded lock for back-to-back transactions. Every granted transaction drives exactly one single-cycle we or re strobe. This matters because register reads and writes have side effects: TDR writes push the TX FIFO, RDR reads pop the RX FIFO, and writes to the flash RAM window are stored. The block sits between the two core bus interfaces and the register file.

Parameters:
ADDR_W, 22, register address width
DATA_W, 32, data width
LOCK_MAX, 4, max consecutive locked grants to one master while the other is requesting (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
m0_req  in  1  master 0 transaction request, held until m0_ack
m0_lock  in  1  master 0 requests to keep priority for its next transaction
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DATA_W  read data, valid when m0_ack = 1, held until the next m0 read
m1_*  same set as m0_* for master 1
s_addr  out  ADDR_W  address to the register file
s_we  out  1  write strobe
s_re  out  1  read strobe
s_wdata  out  DATA_W  write data to the register file
s_rdata  in  DATA_W  combinational read data from the register file
busy  out  1  high in ACCESS and RESP
cur_master  out  1  master owning the current or last transaction

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. Every register updates only on posedge clk.
- Reset values:
  - State IDLE.
  - s_addr, s_wdata, m0_rdata, m1_rdata = 0.
  - s_we, s_re, m0_ack, m1_ack, busy = 0.
  - cur_master = 1, so master 0 wins the first contention.
  - Lock counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick a winner:
    - Only one master requesting: that master wins.
    - Both requesting and the lock condition holds: cur_master wins.
    - Both requesting, no lock: the master != cur_master wins (round robin).
  - On the transition to ACCESS, latch the winner's addr, we and wdata into s_addr/s_wdata and an internal we flag. Set cur_master to the winner.
- Lock condition: cur_master's lock input was high when its last ack was issued, and lock counter < LOCK_MAX.
  - The lock counter increments on each grant given to the same master under contention.
  - It clears when the grant changes master or when the other master is not requesting.
- ACCESS (exactly 1 cycle):
  - s_we = latched we, s_re = !latched we.
  - At the end of the cycle, if the transaction is a read, capture s_rdata into the owner's mN_rdata.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Owner's mN_ack = 1; s_we = s_re = 0.
  - Sample the owner's mN_lock for the lock condition.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle T gives the strobe at T+1 and the ack at T+2. Minimum 3 cycles per transaction.
- Strobe rule: s_we/s_re are high only in ACCESS. Never both high. Exactly one strobe per grant.
- Command latching: once granted, the transaction always completes. Dropping mN_req or changing addr/data after the grant has no effect, and the ack still pulses.
- Back-to-back requests: a master holding req high after its ack is treated as a new request at the next IDLE evaluation.
- Writes leave mN_rdata unchanged. The non-owner's ack and rdata are unaffected.
- rst mid-transaction: the next cycle shows reset values. No strobe or ack is issued for the aborted transaction.
- s_addr and s_wdata hold their last latched values outside ACCESS.

Decomposition:
- Shared defines file regs_arb_defines.v holds:
  - State encodings (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2).
  - Master IDs (M0 = 1'b0, M1 = 1'b1).
  - Default LOCK_MAX.
- One sub-module, rr_lock_picker: combinational winner selection plus the registered lock counter. The FSM and datapath latching stay in regs_bus_arbiter.

Test Plan:
1. After reset, m0 writes addr 22'h0003, data 32'h55 (req at cycle 0) -> s_we=1 only at cycle 1 with s_addr=22'h0003, s_wdata=32'h55; m0_ack=1 only at cycle 2; s_re never high.
2. m1 reads 22'h0004 with s_rdata=32'hA5 -> s_re high 1 cycle; m1_ack with m1_rdata=32'hA5; m0_rdata stays 0.
3. Both masters request reads continuously from reset, no lock -> grant order 0,1,0,1,0,1; one strobe per 3 cycles; acks alternate.
4. Both request continuously, m0_lock=1, LOCK_MAX=4 -> m0 gets 4 consecutive grants (counter saturates), then m1 gets 1, then m0 resumes.
5. m1 drops req and changes addr the cycle after its grant -> original address strobed once, m1_ack still pulses, no second transaction.
6. rst asserted during ACCESS of an m0 write -> next cycle s_we=0, m0_ack=0, busy=0, cur_master=1; no ack ever issued for that write; a fresh m0 request completes normally.

Source files
------------

// File: rtl/regs_bus_arbiter_pkg.sv
// Shared types and constants for the two-master register-port arbiter.
package regs_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int unsigned LOCK_MAX_DEFAULT = 4;
    // Wide enough for the full 1..15 lock range.
    localparam int unsigned LOCK_CNT_W = 4;

endpackage

// File: rtl/rr_lock_picker.sv
// Round-robin winner selection with a bounded lock that lets the last owner keep the port.
module rr_lock_picker
    import regs_bus_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic cur_master,
    input  logic grant_en,
    input  logic lock_sample_en,
    input  logic lock_in,
    output logic winner_c
);

    logic [LOCK_CNT_W-1:0] lock_cnt_q;
    logic [LOCK_CNT_W-1:0] lock_cnt_d;
    logic                  lock_flag_q;
    logic                  lock_flag_d;
    logic                  contended;
    logic                  lock_ok;

    always_comb begin
        lock_cnt_d  = lock_cnt_q;
        lock_flag_d = lock_flag_q;
        contended   = req0 & req1;
        lock_ok     = lock_flag_q && (lock_cnt_q < LOCK_CNT_W'(LOCK_MAX));

        if (contended) begin
            winner_c = lock_ok ? cur_master : ~cur_master;
        end else begin
            winner_c = req1 ? M1 : M0;
        end

        // Count only repeat grants won against a waiting peer; anything else resets the budget.
        if (grant_en) begin
            if (contended && (winner_c == cur_master)) begin
                lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
            end else begin
                lock_cnt_d = '0;
            end
        end

        if (lock_sample_en) begin
            lock_flag_d = lock_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q  <= '0;
            lock_flag_q <= 1'b0;
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            lock_flag_q <= lock_flag_d;
        end
    end

endmodule

// File: rtl/regs_bus_arbiter.sv
// Shares the register-file port between two cores; each grant yields exactly one
// single-cycle we/re strobe followed by a one-cycle ack to the owning master.
module regs_bus_arbiter
    import regs_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 22,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_we,
    output logic              s_re,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy,
    output logic              cur_master
);

    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   s_addr_q,     s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q,    s_wdata_d;
    logic                we_q,         we_d;
    logic                s_we_q,       s_we_d;
    logic                s_re_q,       s_re_d;
    logic                m0_ack_q,     m0_ack_d;
    logic                m1_ack_q,     m1_ack_d;
    logic [DATA_W-1:0]   m0_rdata_q,   m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q,   m1_rdata_d;
    logic                busy_q,       busy_d;
    logic                cur_master_q, cur_master_d;

    logic                winner_c;
    logic                grant_en;
    logic                lock_sample_en;
    logic                owner_lock;

    assign grant_en       = (state_q == ST_IDLE) && (m0_req || m1_req);
    assign lock_sample_en = (state_q == ST_RESP);
    assign owner_lock     = (cur_master_q == M1) ? m1_lock : m0_lock;

    rr_lock_picker #(
        .LOCK_MAX (LOCK_MAX)
    ) u_picker (
        .clk            (clk),
        .rst            (rst),
        .req0           (m0_req),
        .req1           (m1_req),
        .cur_master     (cur_master_q),
        .grant_en       (grant_en),
        .lock_sample_en (lock_sample_en),
        .lock_in        (owner_lock),
        .winner_c       (winner_c)
    );

    always_comb begin
        state_d      = state_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        we_d         = we_q;
        s_we_d       = 1'b0;
        s_re_d       = 1'b0;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        busy_d       = busy_q;
        cur_master_d = cur_master_q;

        unique case (state_q)
            ST_IDLE: begin
                // Latch the winner's command so later changes on its bus are ignored.
                if (grant_en) begin
                    state_d      = ST_ACCESS;
                    cur_master_d = winner_c;
                    we_d         = (winner_c == M1) ? m1_we    : m0_we;
                    s_addr_d     = (winner_c == M1) ? m1_addr  : m0_addr;
                    s_wdata_d    = (winner_c == M1) ? m1_wdata : m0_wdata;
                    s_we_d       = we_d;
                    s_re_d       = ~we_d;
                    busy_d       = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (!we_q) begin
                    if (cur_master_q == M0) begin
                        m0_rdata_d = s_rdata;
                    end else begin
                        m1_rdata_d = s_rdata;
                    end
                end
                if (cur_master_q == M0) begin
                    m0_ack_d = 1'b1;
                end else begin
                    m1_ack_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            we_q         <= 1'b0;
            s_we_q       <= 1'b0;
            s_re_q       <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            busy_q       <= 1'b0;
            cur_master_q <= M1;
        end else begin
            state_q      <= state_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            we_q         <= we_d;
            s_we_q       <= s_we_d;
            s_re_q       <= s_re_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            busy_q       <= busy_d;
            cur_master_q <= cur_master_d;
        end
    end

    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;
    assign s_we       = s_we_q;
    assign s_re       = s_re_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;
    assign busy       = busy_q;
    assign cur_master = cur_master_q;

endmodule

// File: tb/tb_regs_bus_arbiter.sv
// Directed self-checking bench for regs_bus_arbiter; outputs are sampled 1 time unit after posedge.
module tb_regs_bus_arbiter;

    localparam int unsigned ADDR_W   = 22;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LOCK_MAX = 4;

    logic              clk;
    logic              rst;
    logic              m0_req, m0_lock, m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req, m1_lock, m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic [ADDR_W-1:0] s_addr;
    logic              s_we, s_re;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              busy;
    logic              cur_master;

    int n_cmp;
    int n_bad;

    regs_bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_lock    (m0_lock),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_ack     (m0_ack),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_lock    (m1_lock),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_ack     (m1_ack),
        .m1_rdata   (m1_rdata),
        .s_addr     (s_addr),
        .s_we       (s_we),
        .s_re       (s_re),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .busy       (busy),
        .cur_master (cur_master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        s_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Expected owner of each grant with m0_lock held: one round-robin grant, then LOCK_MAX locked ones.
    logic exp_lock_owner [0:7];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_lock_owner[0] = 1'b0; exp_lock_owner[1] = 1'b0;
        exp_lock_owner[2] = 1'b0; exp_lock_owner[3] = 1'b0;
        exp_lock_owner[4] = 1'b0; exp_lock_owner[5] = 1'b1;
        exp_lock_owner[6] = 1'b0; exp_lock_owner[7] = 1'b0;

        // Reset state
        do_reset();
        check("rst_s_addr", 64'(s_addr), 64'h0);
        check("rst_s_wdata", 64'(s_wdata), 64'h0);
        check("rst_s_we", 64'(s_we), 64'h0);
        check("rst_s_re", 64'(s_re), 64'h0);
        check("rst_acks", 64'({m0_ack, m1_ack}), 64'h0);
        check("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_cur_master", 64'(cur_master), 64'h1);

        // Test 1: m0 write, req seen at cycle 0
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h0003; m0_wdata = 32'h55;
        tick();
        check("t1_c1_s_we", 64'(s_we), 64'h1);
        check("t1_c1_s_re", 64'(s_re), 64'h0);
        check("t1_c1_s_addr", 64'(s_addr), 64'h3);
        check("t1_c1_s_wdata", 64'(s_wdata), 64'h55);
        check("t1_c1_m0_ack", 64'(m0_ack), 64'h0);
        check("t1_c1_busy", 64'(busy), 64'h1);
        check("t1_c1_cur", 64'(cur_master), 64'h0);
        m0_req = 1'b0;
        tick();
        check("t1_c2_m0_ack", 64'(m0_ack), 64'h1);
        check("t1_c2_m1_ack", 64'(m1_ack), 64'h0);
        check("t1_c2_strobes", 64'({s_we, s_re}), 64'h0);
        check("t1_c2_busy", 64'(busy), 64'h1);
        check("t1_c2_m0_rdata", 64'(m0_rdata), 64'h0);
        tick();
        check("t1_c3_m0_ack", 64'(m0_ack), 64'h0);
        check("t1_c3_busy", 64'(busy), 64'h0);
        check("t1_c3_addr_hold", 64'(s_addr), 64'h3);
        check("t1_c3_wdata_hold", 64'(s_wdata), 64'h55);

        // Test 2: m1 read
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 22'h0004; s_rdata = 32'hA5;
        tick();
        check("t2_c1_s_re", 64'(s_re), 64'h1);
        check("t2_c1_s_we", 64'(s_we), 64'h0);
        check("t2_c1_s_addr", 64'(s_addr), 64'h4);
        check("t2_c1_cur", 64'(cur_master), 64'h1);
        m1_req = 1'b0;
        tick();
        check("t2_c2_m1_ack", 64'(m1_ack), 64'h1);
        check("t2_c2_m0_ack", 64'(m0_ack), 64'h0);
        check("t2_c2_m1_rdata", 64'(m1_rdata), 64'hA5);
        check("t2_c2_m0_rdata", 64'(m0_rdata), 64'h0);
        check("t2_c2_s_re", 64'(s_re), 64'h0);
        s_rdata = 32'h1111;
        tick();
        check("t2_c3_m1_ack", 64'(m1_ack), 64'h0);
        check("t2_c3_m1_rdata_hold", 64'(m1_rdata), 64'hA5);

        // m1 write must not disturb m1_rdata
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 22'h0008; m1_wdata = 32'hBEEF;
        tick();
        check("t2w_s_we", 64'(s_we), 64'h1);
        m1_req = 1'b0;
        tick();
        check("t2w_m1_ack", 64'(m1_ack), 64'h1);
        check("t2w_m1_rdata_kept", 64'(m1_rdata), 64'hA5);
        tick();

        // Test 3: both read continuously, no lock -> 0,1,0,1,0,1
        do_reset();
        m0_req = 1'b1; m0_addr = 22'h0010; m1_req = 1'b1; m1_addr = 22'h0011;
        s_rdata = 32'hC3;
        for (int i = 1; i <= 18; i++) begin
            logic exp_owner;
            tick();
            exp_owner = 1'(((i - 1) / 3) % 2);
            check("t3_s_re", 64'(s_re), 64'((i % 3) == 1));
            check("t3_s_we", 64'(s_we), 64'h0);
            check("t3_m0_ack", 64'(m0_ack), 64'(((i % 3) == 2) && !exp_owner));
            check("t3_m1_ack", 64'(m1_ack), 64'(((i % 3) == 2) && exp_owner));
            if ((i % 3) == 1) begin
                check("t3_owner", 64'(cur_master), 64'(exp_owner));
                check("t3_s_addr", 64'(s_addr), exp_owner ? 64'h11 : 64'h10);
            end
        end

        // Test 4: both request, m0 locks
        do_reset();
        m0_req = 1'b1; m0_lock = 1'b1; m1_req = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check("t4_one_strobe", 64'(s_re), 64'((i % 3) == 1));
            if ((i % 3) == 1) begin
                check("t4_owner", 64'(cur_master), 64'(exp_lock_owner[(i - 1) / 3]));
            end
        end

        // Test 5: m1 drops req and changes addr after its grant
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 22'h0007; s_rdata = 32'h77;
        tick();
        check("t5_s_re", 64'(s_re), 64'h1);
        check("t5_s_addr", 64'(s_addr), 64'h7);
        m1_req = 1'b0; m1_addr = 22'h0009;
        tick();
        check("t5_m1_ack", 64'(m1_ack), 64'h1);
        check("t5_m1_rdata", 64'(m1_rdata), 64'h77);
        check("t5_s_addr_latched", 64'(s_addr), 64'h7);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_strobe", 64'({s_we, s_re}), 64'h0);
            check("t5_no_ack", 64'({m0_ack, m1_ack}), 64'h0);
            check("t5_idle", 64'(busy), 64'h0);
        end

        // Test 6: reset during ACCESS of an m0 write
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h0005; m0_wdata = 32'hDEAD;
        tick();
        check("t6_access_s_we", 64'(s_we), 64'h1);
        rst = 1'b1;
        tick();
        check("t6_rst_s_we", 64'(s_we), 64'h0);
        check("t6_rst_m0_ack", 64'(m0_ack), 64'h0);
        check("t6_rst_busy", 64'(busy), 64'h0);
        check("t6_rst_cur", 64'(cur_master), 64'h1);
        check("t6_rst_s_addr", 64'(s_addr), 64'h0);
        tick();
        check("t6_rst2_m0_ack", 64'(m0_ack), 64'h0);
        rst = 1'b0; m0_addr = 22'h0006; m0_wdata = 32'h1234;
        tick();
        check("t6_fresh_s_we", 64'(s_we), 64'h1);
        check("t6_fresh_s_addr", 64'(s_addr), 64'h6);
        check("t6_fresh_s_wdata", 64'(s_wdata), 64'h1234);
        m0_req = 1'b0;
        tick();
        check("t6_fresh_m0_ack", 64'(m0_ack), 64'h1);
        tick();
        check("t6_done_ack", 64'(m0_ack), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
